// File: rtl/pipe_pkg.sv
// Shared types and defaults for the generic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// Width-generic register with enable and a clear that restores the reset value.
module pipe_entry_reg #(
  parameter int unsigned   W         = 1,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a flushed or drained entry never keeps stale data.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a one-entry skid buffer, flush and a
// saturating back-pressure counter; in_ready comes straight from a flop.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W       = 64,
  parameter int unsigned     PAYLOAD_W  = 256,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEFAULT),
  parameter logic [31:0]     RESET_INST = NOP_INST,
  parameter int unsigned     CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [31:0]          out_inst,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int unsigned      ENT_W    = PC_W + INST_W + PAYLOAD_W;
  localparam logic [ENT_W-1:0] HEAD_RST = {RESET_PC, RESET_INST, {PAYLOAD_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic             in_fire, out_fire;
  logic             head_load, head_from_skid, head_clr;
  logic             skid_load, skid_clr;
  logic [ENT_W-1:0] in_ent, head_d, head_q, skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign in_ent   = {in_pc, in_inst, in_payload};
  assign head_d   = head_from_skid ? skid_q : in_ent;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and entry-register controls; flush drops everything, including a same-cycle in_fire.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_load = 1'b1;
            state_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (out_fire) begin
            head_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          head_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_entry_reg #(
    .W         (ENT_W),
    .RESET_VAL (HEAD_RST)
  ) u_head (
    .clk (clk),
    .rst (rst),
    .clr (head_clr),
    .en  (head_load | head_from_skid),
    .d   (head_d),
    .q   (head_q)
  );

  pipe_entry_reg #(
    .W         (ENT_W),
    .RESET_VAL ('0)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (skid_clr),
    .en  (skid_load),
    .d   (in_ent),
    .q   (skid_q)
  );

  assign {out_pc, out_inst, out_payload} = head_q;

  // Handshake flags precomputed from the next state so both leave the block as flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= (state_d != ST_EMPTY);
      in_ready  <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
